// File: rtl/mips_mc_pc_control.sv
// Multicycle MIPS main control FSM: sequences PC, memory, IR, register-file and ALU controls.
// Optional MIPS_PC_CTRL_BNE_EN adds bne (opcode 000101) as a BRANCH variant taken on ~zero.
module mips_mc_pc_control #(
  parameter int unsigned USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ior,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state, state_next;
  logic   rdy;
  logic   br_take;
  logic   pc_en_c, ir_write_c, mem_write_c, reg_write_c;

  assign rdy     = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign state_o = state;

`ifdef MIPS_PC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE = 6'b000101;
  logic is_bne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              is_bne <= 1'b0;
    else if (state == DECODE) is_bne <= (opcode == OP_BNE);
  end

  assign br_take = is_bne ? ~zero : zero;
`else
  assign br_take = zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:   state_next = rdy ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
`ifdef MIPS_PC_CTRL_BNE_EN
          OP_BNE:       state_next = BRANCH;
`endif
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR:  state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_next = rdy ? MEMWB : MEMRD;
      MEMWR:   state_next = rdy ? FETCH : MEMWR;
      EXECUTE: state_next = ALUWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    pc_en_c     = 1'b0;
    pc_src      = 2'b00;
    ior         = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b01;
        ir_write_c = rdy;
        pc_en_c    = rdy;
      end
      DECODE:  alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD:   ior = 1'b1;
      MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_c = 1'b1;
        instr_done  = 1'b1;
      end
      MEMWR: begin
        ior         = 1'b1;
        mem_write_c = 1'b1;
        instr_done  = rdy;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_c = 1'b1;
        instr_done  = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en_c    = br_take;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        instr_done  = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_en_c    = 1'b1;
        instr_done = 1'b1;
      end
      TRAP: begin
        pc_src     = 2'b11;
        pc_en_c    = 1'b1;
        illegal_op = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are masked by rst_n so none can fire while reset is held.
  assign pc_en     = pc_en_c     & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign reg_write = reg_write_c & rst_n;

endmodule

// File: tb/tb_mips_mc_pc_control.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle control vectors.
module tb_mips_mc_pc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ior, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal_op, instr_done;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  mips_mc_pc_control #(.USE_MEM_READY(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .ior(ior), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .instr_done(instr_done),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {state_o, pc_en, pc_src, ior, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, instr_done};

  function automatic logic [19:0] mk(input logic [3:0] st, input logic pe, input logic [1:0] ps,
                                     input logic io, input logic mw, input logic irw,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic ill, input logic dn);
    return {st, pe, ps, io, mw, irw, rd, m2r, rw, asa, asb, aop, ill, dn};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input logic [19:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic rdy, input logic [19:0] exp, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check(exp, tag);
    cyc++;
  endtask

  // Expected behaviour derived from the instruction class, zero flag and wait counts.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                           output int cycles);
    logic taken;
    opcode = op;
    zero   = z;
    cyc    = 0;
    for (int i = 0; i < fw; i++)
      step(1'b0, mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0), "fetch_wait");
    step(1'b1, mk(0, 1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0), "fetch");
    step(rbit(), mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0), "decode");
    case (op)
      6'b100011: begin
        step(rbit(), mk(2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0), "lw_memadr");
        for (int i = 0; i < mw; i++)
          step(1'b0, mk(3, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "lw_stall");
        step(1'b1, mk(3, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "lw_memrd");
        step(rbit(), mk(4, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1), "lw_memwb");
      end
      6'b101011: begin
        step(rbit(), mk(2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0), "sw_memadr");
        for (int i = 0; i < mw; i++)
          step(1'b0, mk(5, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "sw_stall");
        step(1'b1, mk(5, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1), "sw_memwr");
      end
      6'b000000: begin
        step(rbit(), mk(6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0), "r_execute");
        step(rbit(), mk(7, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1), "r_aluwb");
      end
      6'b000100:
        step(rbit(), mk(8, z, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 1), "beq_branch");
`ifdef MIPS_PC_CTRL_BNE_EN
      6'b000101: begin
        taken = ~z;
        step(rbit(), mk(8, taken, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 1), "bne_branch");
      end
`endif
      6'b001000: begin
        step(rbit(), mk(9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0), "addi_ex");
        step(rbit(), mk(10, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1), "addi_wb");
      end
      6'b000010:
        step(rbit(), mk(11, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1), "jump");
      default:
        step(rbit(), mk(12, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1), "trap");
    endcase
    cycles = cyc;
  endtask

  logic [19:0] fetch_rst;
  logic [5:0]  ops [8];
  int          ncyc;

  initial begin
    fetch_rst = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b000101; ops[7] = 6'b111111;

    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0;
    #1 check(fetch_rst, "reset_state");
    repeat (2) @(negedge clk);
    check(fetch_rst, "reset_held");
    rst_n = 1'b1; mem_ready = 1'b0;

    run_instr(6'b000000, 1'b0, 0, 0, ncyc);
    n_checks++;
    assert (ncyc == 4) n_pass++; else $error("FAIL rtype_latency observed=%0d expected=4", ncyc);

    run_instr(6'b100011, 1'b0, 0, 3, ncyc);
    n_checks++;
    assert (ncyc == 8) n_pass++; else $error("FAIL lw_latency observed=%0d expected=8", ncyc);

    run_instr(6'b000100, 1'b1, 0, 0, ncyc);
    run_instr(6'b000100, 1'b0, 1, 0, ncyc);
    run_instr(6'b000010, 1'b0, 0, 0, ncyc);
    n_checks++;
    assert (ncyc == 3) n_pass++; else $error("FAIL j_latency observed=%0d expected=3", ncyc);
    run_instr(6'b111111, 1'b0, 0, 0, ncyc);
    run_instr(6'b000101, 1'b0, 0, 0, ncyc);
    run_instr(6'b000101, 1'b1, 0, 0, ncyc);
    run_instr(6'b101011, 1'b0, 2, 1, ncyc);

    // Reset dropped in the middle of a store wait.
    opcode = 6'b101011;
    step(1'b1, mk(0, 1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0), "rst_fetch");
    step(1'b0, mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0), "rst_decode");
    step(1'b0, mk(2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0), "rst_memadr");
    step(1'b0, mk(5, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "rst_memwr");
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 check(fetch_rst, "rst_async_drop");
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1 check(fetch_rst, "rst_release_fetch");
    run_instr(6'b001000, 1'b0, 0, 0, ncyc);

    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 7)];
      if (op == 6'b111111) op = 6'($urandom);
      run_instr(op, rbit(), $urandom_range(0, 3), $urandom_range(0, 3), ncyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_pc_control.md
Name: mips_mc_pc_control

Overview:
- Multicycle MIPS main control FSM.
- Sequences the PC datapath: drives the PC-source select (00 ALU result, 01 ALU out, 10 jump target, 11 trap vector 0xFFFF_FFFF) and the PC write enable.
- Also drives memory, IR, register-file and ALU control for each instruction phase.
- Stalls on a memory ready handshake; redirects illegal opcodes to the trap vector.

Parameters:
- USE_MEM_READY, 1: 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored, treated as 1.

Ports:
- Interface (already decided): one clock `clk`; reset `rst_n`, asynchronous, active-low.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC register load enable
- pc_src  out  2  PC-source select
- ior  out  1  0 = memory address from PC, 1 = from ALU out
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALU out
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct
- illegal_op  out  1  one-cycle pulse in TRAP
- instr_done  out  1  one-cycle pulse on the last state of each instruction
- state_o  out  4  current state code (debug)

Behaviour:
- Moore FSM, one state register, 4 bits. Outputs decode from state; pc_en, ir_write and memory-wait transitions also depend on mem_ready/zero.
- Any output not listed for a state is 0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12.
- Reset: rst_n low forces state = FETCH asynchronously. While rst_n is low, pc_en, ir_write, mem_write, reg_write = 0; other outputs show FETCH values.
- FETCH:
  - ior=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_en = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; else -> TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: ior=1. Waits on mem_ready, then MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1, instr_done=1. Next FETCH.
- MEMWR: ior=1, mem_write=1, held for the whole wait. Waits on mem_ready; instr_done=1 in the completing cycle. Next FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
- ALUWB: reg_dst=1, reg_write=1, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10. Next ADDIWB.
- ADDIWB: reg_write=1, instr_done=1. Next FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Next FETCH.
- TRAP: pc_src=11, pc_en=1, illegal_op=1, instr_done=1. Next FETCH.
- Unused state codes 13-15 go to FETCH on the next edge, with all outputs 0.
- Latency: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4, each plus memory wait cycles.
- Reset mid-instruction: the access in progress is abandoned and no write enable fires after rst_n falls.

Optional Feature:
- Macro: MIPS_PC_CTRL_BNE_EN.
- Defined: opcode 000101 (bne) in DECODE -> BRANCH. BRANCH latches bne on DECODE exit and sets pc_en = ~zero.
- Undefined: 000101 -> TRAP.

Test Plan:
- Reset asserted mid-MEMWR (mem_write=1) -> mem_write drops to 0 asynchronously; after release, state_o=0 and the first edge with mem_ready=1 gives pc_en=1, ir_write=1.
- R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0; reg_write=1, reg_dst=1 only in ALUWB; instr_done pulses once.
- lw with mem_ready low for 3 cycles in MEMRD -> 3 stall cycles with ior=1; MEMWB reached with mem_to_reg=1; total 8 cycles.
- beq: zero=1 -> pc_en=1, pc_src=01 in BRANCH; zero=0 -> pc_en=0.
- j (000010) -> pc_src=10, pc_en=1. Opcode 111111 -> TRAP: pc_src=11, pc_en=1, illegal_op=1 for exactly one cycle, then FETCH.
- Opcode 000101 -> TRAP without the macro; BRANCH with it, taken when zero=0.
